// File: rtl/ram_stream_reader_if.sv
// Purpose: bundles the command, RAM read and output stream signals of ram_stream_reader.
// Ports: start/base/count/busy/done (command), addr/data (RAM read),
//        out_data/out_valid/out_ready/out_last (valid/ready stream).
// master = the reader itself; slave = the environment (command source, RAM, consumer).
interface ram_stream_reader_if #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 4
);
  logic              start;
  logic [AWIDTH-1:0] base;
  logic [AWIDTH:0]   count;
  logic              busy;
  logic              done;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] data;
  logic [DWIDTH-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    input  start, base, count, data, out_ready,
    output busy, done, addr, out_data, out_valid, out_last
  );

  modport slave (
    output start, base, count, data, out_ready,
    input  busy, done, addr, out_data, out_valid, out_last
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Purpose: sweeps a wrapping RAM address window on start and streams each word out.
// Latency: start at edge N -> first beat registered at edge N+1; then one beat per cycle.
// Backpressure: out_valid & !out_ready freezes addr, out_data and out_last; nothing is lost.
// Ports: clk, rst (sync, active-high); bus (master modport) carries command, RAM read
//        address/data and the output stream; done pulses one cycle after the final handshake.
module ram_stream_reader #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  ram_stream_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [AWIDTH-1:0] addr_reg;
  logic [AWIDTH:0]   remaining;
  logic [DWIDTH-1:0] out_data_reg;
  logic              out_valid_reg;
  logic              out_last_reg;
  logic              done_reg;

  logic handshake;
  logic capture;

  assign handshake = out_valid_reg & bus.out_ready;
  // A new word may enter the output register when it is empty or being drained this cycle.
  assign capture   = (state == RUN) && (remaining != '0) && (!out_valid_reg || bus.out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr_reg      <= '0;
      remaining     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.count != '0) begin
              addr_reg  <= bus.base;
              remaining <= bus.count;
              state     <= RUN;
            end else begin
              // Empty command completes immediately without touching the stream.
              done_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (capture) begin
            out_data_reg  <= bus.data;
            out_valid_reg <= 1'b1;
            out_last_reg  <= (remaining == (AWIDTH+1)'(1));
            addr_reg      <= addr_reg + AWIDTH'(1);
            remaining     <= remaining - (AWIDTH+1)'(1);
            if (remaining == (AWIDTH+1)'(1)) begin
              state <= DRAIN;
            end
          end else if (handshake) begin
            out_valid_reg <= 1'b0;
          end
        end
        DRAIN: begin
          if (handshake) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            done_reg      <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.addr      = addr_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Purpose: directed bench for ram_stream_reader against a RAM holding mem[i]=i.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Each scenario task checks its own expectations inline.
module tb_ram_stream_reader;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] mem [16];

  always #5 clk = ~clk;

  ram_stream_reader_if #(.AWIDTH(4), .DWIDTH(4)) bus ();

  ram_stream_reader #(.AWIDTH(4), .DWIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Combinational RAM read port
  assign bus.data = mem[bus.addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for exactly one edge, then scrambles base/count.
  task automatic issue(input logic [3:0] b, input logic [4:0] c);
    bus.base  = b;
    bus.count = c;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.base  = ~b;
    bus.count = 5'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    checks++; if (bus.addr !== 4'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", bus.addr); end
    checks++; if (bus.out_data !== 4'd0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_outs got d=%0d v=%0b l=%0b done=%0b want all 0", bus.out_data, bus.out_valid, bus.out_last, bus.done);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    issue(4'd3, 5'd4);
    checks++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_start got busy=%0b v=%0b want busy=1 v=0", bus.busy, bus.out_valid); end
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'(3 + k) || bus.out_last !== (k == 3) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++; $display("FAIL basic_beat%0d got v=%0b d=%0d l=%0b busy=%0b done=%0b want v=1 d=%0d l=%0b busy=1 done=0",
                           k, bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.done, 3 + k, (k == 3));
      end
      step();
    end
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_done got done=%0b busy=%0b v=%0b want 1 0 0", bus.done, bus.busy, bus.out_valid); end
    step();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%0b want=0", bus.done); end
  endtask

  task automatic test_wrap();
    logic [3:0] ed;
    logic [3:0] ea;
    issue(4'd14, 5'd4);
    checks++; if (bus.addr !== 4'd14) begin errors++; $display("FAIL wrap_addr0 got=%0d want=14", bus.addr); end
    step();
    for (int k = 0; k < 4; k++) begin
      ed = 4'(14 + k);
      ea = 4'(15 + k);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== ed || bus.addr !== ea) begin
        errors++; $display("FAIL wrap_beat%0d got v=%0b d=%0d a=%0d want v=1 d=%0d a=%0d", k, bus.out_valid, bus.out_data, bus.addr, ed, ea);
      end
      step();
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL wrap_done got=%0b want=1", bus.done); end
    step();
  endtask

  task automatic test_backpressure();
    logic       pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int         acc = 0;
    logic [3:0] ea;
    bus.out_ready = 1'b0;
    issue(4'd0, 5'd3);
    step();
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = pat[i];
      ea = 4'(1 + acc);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'(acc) || bus.addr !== ea) begin
        errors++; $display("FAIL bp_cycle%0d got v=%0b d=%0d a=%0d want v=1 d=%0d a=%0d", i, bus.out_valid, bus.out_data, bus.addr, acc, ea);
      end
      if (bus.out_valid === 1'b1 && pat[i]) acc++;
      step();
    end
    checks++; if (acc !== 3) begin errors++; $display("FAIL bp_accepted got=%0d want=3", acc); end
    checks++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_done got done=%0b v=%0b want 1 0", bus.done, bus.out_valid); end
    bus.out_ready = 1'b1;
    step();
  endtask

  task automatic test_full_and_empty();
    logic [3:0] ed;
    issue(4'd5, 5'd16);
    step();
    for (int k = 0; k < 16; k++) begin
      ed = 4'(5 + k);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== ed || bus.out_last !== (k == 15)) begin
        errors++; $display("FAIL full_beat%0d got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b", k, bus.out_valid, bus.out_data, bus.out_last, ed, (k == 15));
      end
      step();
    end
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL full_done got done=%0b busy=%0b want 1 0", bus.done, bus.busy); end
    step();
    issue(4'd7, 5'd0);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL empty_cmd got done=%0b busy=%0b v=%0b want 1 0 0", bus.done, bus.busy, bus.out_valid);
    end
    step();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL empty_after got done=%0b busy=%0b v=%0b want 0 0 0", bus.done, bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_restart_ignored();
    issue(4'd1, 5'd3);
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'(1 + k) || bus.out_last !== (k == 2)) begin
        errors++; $display("FAIL restart_beat%0d got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b", k, bus.out_valid, bus.out_data, bus.out_last, 1 + k, (k == 2));
      end
      if (k == 1) begin
        bus.base  = 4'd9;
        bus.count = 5'd2;
        bus.start = 1'b1;
      end
      step();
      bus.start = 1'b0;
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL restart_done got=%0b want=1", bus.done); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL restart_idle%0d got v=%0b busy=%0b want 0 0", i, bus.out_valid, bus.busy);
      end
    end
  endtask

  task automatic test_abort();
    issue(4'd6, 5'd5);
    step();
    step();
    checks++; if (bus.out_data !== 4'd7 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL abort_pre got d=%0d v=%0b want d=7 v=1", bus.out_data, bus.out_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.addr !== 4'd0 || bus.out_data !== 4'd0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL abort_clear got busy=%0b a=%0d d=%0d v=%0b l=%0b done=%0b want all 0",
                         bus.busy, bus.addr, bus.out_data, bus.out_valid, bus.out_last, bus.done);
    end
    step();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_nodone got done=%0b busy=%0b v=%0b want 0 0 0", bus.done, bus.busy, bus.out_valid);
    end
    issue(4'd2, 5'd2);
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'(2 + k) || bus.out_last !== (k == 1)) begin
        errors++; $display("FAIL abort_beat%0d got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b", k, bus.out_valid, bus.out_data, bus.out_last, 2 + k, (k == 1));
      end
      step();
    end
    checks++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_done got done=%0b v=%0b want 1 0", bus.done, bus.out_valid); end
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.base      = 4'd0;
    bus.count     = 5'd0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_full_and_empty();
    test_restart_ignored();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
Downstream read sequencer for the single-port-read RAM. It drives the RAM read address and consumes the RAM's combinational read data. On a start command it sweeps a contiguous, wrapping address window and emits each word as a valid/ready stream beat, with a last flag and a completion pulse. It registers the data so the stream output has no combinational path from the RAM.

Parameters:
AWIDTH, 4, RAM address width; the window wraps modulo 2**AWIDTH.
DWIDTH, 4, RAM data width and stream data width.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
start  input  1  command strobe; sampled only in IDLE.
base  input  AWIDTH  first address of the window; sampled with start.
count  input  AWIDTH+1  number of words, 0..2**AWIDTH; sampled with start.
busy  output  1  high in RUN and DRAIN.
addr  output  AWIDTH  RAM read address; connects to the RAM addr input.
data  input  DWIDTH  RAM read data, combinational from addr.
out_data  output  DWIDTH  stream payload.
out_valid  output  1  stream valid.
out_ready  input  1  stream ready from the consumer.
out_last  output  1  marks the final beat; qualified by out_valid.
done  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (rst high at a clock edge): the state goes to IDLE and every output register clears.
  - busy=0, addr=0, out_data=0, out_valid=0, out_last=0, done=0, remaining=0.
  - Reset aborts any transfer in progress. Partial beats are discarded and done is not pulsed.
- Internal registers: state {IDLE, RUN, DRAIN}, addr_reg (drives addr directly), remaining (AWIDTH+1 bits).
- IDLE, start=1, count!=0:
  - addr_reg<=base, remaining<=count, state->RUN.
- IDLE, start=1, count=0:
  - done<=1 for one cycle; state stays IDLE; busy stays 0; no beat is emitted.
- start outside IDLE is ignored. The sampled base and count are not affected by later input changes.
- RUN capture condition: remaining!=0 and (out_valid==0 or out_ready==1). When the condition holds:
  - out_data<=data (the RAM word at the current addr_reg).
  - out_valid<=1.
  - out_last<=(remaining==1).
  - addr_reg<=addr_reg+1, wrapping 2**AWIDTH-1 -> 0.
  - remaining<=remaining-1.
  - If remaining==1, state->DRAIN.
- RUN with out_valid=1 and out_ready=0: all registers hold. out_data, out_last and addr stay stable and no beat is lost.
- DRAIN:
  - On out_valid & out_ready: out_valid<=0, out_last<=0, done<=1 for one cycle, state->IDLE.
  - Otherwise hold.
- A handshake in RUN that does not coincide with a capture clears out_valid. With correct logic this cannot occur, because any accepted beat in RUN triggers a capture.
- Latency: start at edge N -> first capture at edge N+1 -> out_valid visible after edge N+1.
- Throughput: one beat per cycle with out_ready held high.
- done rises the cycle after the final handshake.
- addr holds its last value in IDLE, so the RAM output stays stable.
- RAM writes on other ports are not coordinated. A word is read at its capture cycle.
- Arithmetic is unsigned. The remaining counter never underflows, because capture is gated by remaining!=0.

Test Plan:
The RAM is initialised mem[i]=i, with AWIDTH=DWIDTH=4 and out_ready=1 unless stated.
1. start, base=3, count=4 -> beats 3,4,5,6 on consecutive cycles; out_last only on 6; done pulses one cycle after beat 6; busy high from the cycle after start until done.
2. Wrap: base=14, count=4 -> beats 14,15,0,1; addr sequence 14,15,0,1.
3. Backpressure: base=0, count=3, out_ready pattern 0,0,1,0,1,1 -> out_data holds 0 through the stalls; exactly beats 0,1,2 are accepted; addr advances only on accepted beats.
4. Full sweep plus boundary: base=5, count=16 -> beats 5..15 then 0..4 (16 beats); last on 4. Then count=0 -> no out_valid, done pulses the cycle after start, busy stays 0.
5. start pulsed again mid-transfer with base=9, count=2 -> ignored; the original sequence completes unchanged.
6. rst asserted after 2 of 5 beats -> next cycle all outputs are 0 and state is IDLE with no done pulse. A following start with base=2, count=2 -> beats 2,3 and a normal done.
